// File: rtl/vga_board_pkg.sv
// vga_board_pkg: raster timing, board geometry, colours, tile palette and fetch FSM states
package vga_board_pkg;
  localparam logic [9:0] HBP = 10'd144;
  localparam logic [9:0] HFP = 10'd784;
  localparam logic [9:0] HPIXELS = 10'd800;
  localparam logic [9:0] VBP = 10'd31;
  localparam logic [9:0] VFP = 10'd511;
  localparam logic [9:0] BOARD_X0 = 10'd120;
  localparam logic [9:0] BOARD_Y0 = 10'd40;
  localparam logic [9:0] BOARD_SPAN = 10'd400;
  localparam logic [6:0] TILE_LAST = 7'd99;
  localparam logic [6:0] GAP = 7'd4;
  localparam logic [9:0] BX0 = HBP + BOARD_X0;
  localparam logic [9:0] BX1 = BX0 + BOARD_SPAN;
  localparam logic [9:0] BY0 = VBP + BOARD_Y0;
  localparam logic [9:0] BY1 = BY0 + BOARD_SPAN;
  localparam logic [11:0] BG = 12'h222;
  localparam logic [11:0] BORDER = 12'h445;
  localparam logic [11:0] WIN = 12'h071;
  typedef enum logic [1:0] {IDLE, REQ, NEXT} state_t;
  function automatic logic [11:0] palette(input logic [3:0] e);
    case (e)
      4'd0: return 12'hCBA;
      4'd1: return 12'hEED;
      4'd2: return 12'hEEC;
      4'd3: return 12'hFB7;
      4'd4: return 12'hF96;
      4'd5: return 12'hF75;
      4'd6: return 12'hF53;
      4'd7: return 12'hEC7;
      4'd8: return 12'hEC6;
      4'd9: return 12'hEC5;
      4'd10: return 12'hEC3;
      4'd11: return 12'hEC2;
      default: return 12'h333;
    endcase
  endfunction
endpackage

// File: rtl/vga_board_fetch_ctrl_tile_locator.sv
// vga_tile_locator: incremental tile column/row tracking from the raw hc/vc counters
module vga_tile_locator
  import vga_board_pkg::*;
(
  input  logic       dclk,
  input  logic       clr,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  output logic       on_board,
  output logic       in_gap,
  output logic [1:0] col,
  output logic [1:0] row,
  output logic       next_row_valid,
  output logic [1:0] next_row
);
  logic [6:0] px, ln;
  logic [9:0] vn;
  assign vn = vc + 10'd1;
  // pixel-in-tile and tile column, restarted just before the board left edge
  always_ff @(posedge dclk or posedge clr)
    if (clr) begin
      px <= '0;
      col <= '0;
    end else if (hc == BX0 - 10'd1) begin
      px <= '0;
      col <= '0;
    end else if (px == TILE_LAST) begin
      px <= '0;
      col <= col + 2'd1;
    end else px <= px + 7'd1;
  // line-in-tile and tile row, stepped at end of line, restarted entering the board top
  always_ff @(posedge dclk or posedge clr)
    if (clr) begin
      ln <= '0;
      row <= '0;
    end else if (hc == HPIXELS - 10'd1) begin
      if (vn == BY0) begin
        ln <= '0;
        row <= '0;
      end else if (ln == TILE_LAST) begin
        ln <= '0;
        row <= row + 2'd1;
      end else ln <= ln + 7'd1;
    end
  assign on_board = hc >= BX0 && hc < BX1 && vc >= BY0 && vc < BY1;
  assign in_gap = px < GAP || ln < GAP;
  assign next_row_valid = vn >= BY0 && vn < BY1;
  assign next_row = (vc == BY0 - 10'd1) ? 2'd0 : (ln == TILE_LAST) ? row + 2'd1 : row;
endmodule

// File: rtl/vga_board_fetch_ctrl.sv
// vga_board_fetch_ctrl: per-line board row fetch and pixel colouring; VGA_WIN_OVERLAY_EN adds the win overlay
module vga_board_fetch_ctrl
  import vga_board_pkg::*;
(
  input  logic       dclk,
  input  logic       clr,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  output logic       rd_req,
  output logic [3:0] rd_addr,
  input  logic       rd_ack,
  input  logic [3:0] rd_data,
  output logic       fetch_err,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
`ifdef VGA_WIN_OVERLAY_EN
  ,
  input  logic       win
`endif
);
  state_t st;
  logic [1:0] r, c, tcol, trow, nrow;
  logic on_board, in_gap, nrow_ok, active;
  logic [3:0][3:0] lbuf;
  logic [11:0] bg, pix;
  vga_tile_locator u_loc (
    .dclk(dclk), .clr(clr), .hc(hc), .vc(vc),
    .on_board(on_board), .in_gap(in_gap), .col(tcol), .row(trow),
    .next_row_valid(nrow_ok), .next_row(nrow)
  );
`ifdef VGA_WIN_OVERLAY_EN
  assign bg = win ? WIN : BG;
`else
  assign bg = BG;
`endif
  assign active = hc >= HBP && hc < HFP && vc >= VBP && vc < VFP;
  // colour of the pixel currently addressed by hc/vc
  always_comb pix = !active ? 12'h000 : !on_board ? bg : in_gap ? BORDER : palette(lbuf[tcol]);
  // fetch FSM: four reads per line in blanking, aborted at the next line's active start
  always_ff @(posedge dclk or posedge clr)
    if (clr) begin
      st <= IDLE;
      r <= '0;
      c <= '0;
      rd_req <= 1'b0;
      rd_addr <= '0;
      fetch_err <= 1'b0;
      lbuf <= '0;
    end else if (st != IDLE && hc == HBP) begin
      fetch_err <= 1'b1;
      rd_req <= 1'b0;
      st <= IDLE;
      for (int i = 0; i < 4; i++)
        if (2'(i) > c || (2'(i) == c && st == REQ)) lbuf[i] <= '0;
    end else if (st == IDLE) begin
      if (hc == HFP && nrow_ok) begin
        st <= REQ;
        r <= nrow;
        c <= '0;
        rd_req <= 1'b1;
        rd_addr <= {nrow, 2'b00};
      end
    end else if (st == REQ) begin
      if (rd_ack) begin
        lbuf[c] <= rd_data;
        rd_req <= 1'b0;
        st <= NEXT;
      end
    end else if (c == 2'd3) st <= IDLE;
    else begin
      c <= c + 2'd1;
      rd_addr <= {r, c + 2'd1};
      rd_req <= 1'b1;
      st <= REQ;
    end
  // registered pixel output, one cycle behind hc
  always_ff @(posedge dclk or posedge clr)
    if (clr) {red, green, blue} <= '0;
    else {red, green, blue} <= pix;
endmodule

// File: tb/tb_vga_board_fetch_ctrl.sv
// tb_vga_board_fetch_ctrl: raster-driven check of row fetches, error flag and rendered pixels
module tb_vga_board_fetch_ctrl;
`ifdef VGA_WIN_OVERLAY_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  logic dclk = 1'b0, clr = 1'b1;
  logic [9:0] hc = '0, vc = '0;
  logic rd_req, rd_ack = 1'b0, fetch_err, win = 1'b0;
  logic [3:0] rd_addr, rd_data = '0, red, green, blue;
  int checks = 0, failures = 0;
  logic [3:0] board [16];
  logic [3:0] lbm [4];
  logic [11:0] pal [16];
  bit fetching, err_exp, junk;
  int frow, nack, wcnt, dly, dmin, dmax, acks_left;

  always #5 dclk = ~dclk;

  vga_board_fetch_ctrl dut (
    .dclk(dclk), .clr(clr), .hc(hc), .vc(vc),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .fetch_err(fetch_err), .red(red), .green(green), .blue(blue)
`ifdef VGA_WIN_OVERLAY_EN
    , .win(win)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_pix(input int h, input int v, input logic w);
    int x, y;
    x = h - 144;
    y = v - 31;
    if (h < 144 || h >= 784 || v < 31 || v >= 511) return 12'h000;
    if (x < 120 || x >= 520 || y < 40 || y >= 440) return (OVL && w) ? 12'h071 : 12'h222;
    if ((x - 120) % 100 < 4 || (y - 40) % 100 < 4) return 12'h445;
    return pal[lbm[(x - 120) / 100]];
  endfunction

  task automatic new_board();
    for (int i = 0; i < 16; i++) board[i] = 4'($urandom_range(0, 11));
  endtask

  task automatic cyc(input int v, input int h, input int clr_at);
    vc = 10'(v);
    hc = 10'(h);
    win = 1'($urandom_range(0, 1));
    @(posedge dclk);
    @(negedge dclk);
    if (h == 144 && fetching) begin
      if (nack < 4) begin
        err_exp = 1'b1;
        for (int i = 0; i < 4; i++) if (i >= nack) lbm[i] = 4'd0;
      end
      fetching = 1'b0;
    end
    if (h == 784 && v + 1 >= 71 && v + 1 < 471) begin
      fetching = 1'b1;
      frow = (v + 1 - 71) / 100;
      nack = 0;
    end
    if (fetching && rd_req === 1'b1) chk("rd_addr", 32'(rd_addr), 32'(frow * 4 + nack));
    if (!fetching) chk("rd_req_idle", 32'(rd_req), 32'd0);
    chk("fetch_err", 32'(fetch_err), 32'(err_exp));
    chk("rgb", 32'({red, green, blue}), 32'(exp_pix(h, v, win)));
    if (h == clr_at) begin
      clr = 1'b1;
      #2;
      chk("clr_rd_req", 32'(rd_req), 32'd0);
      chk("clr_rd_addr", 32'(rd_addr), 32'd0);
      chk("clr_fetch_err", 32'(fetch_err), 32'd0);
      chk("clr_rgb", 32'({red, green, blue}), 32'd0);
      clr = 1'b0;
      fetching = 1'b0;
      err_exp = 1'b0;
      nack = 0;
      for (int i = 0; i < 4; i++) lbm[i] = 4'd0;
    end
    wcnt = (rd_req === 1'b1) ? wcnt + 1 : 0;
    if (wcnt == 1) dly = int'($urandom_range(dmin, dmax));
    rd_ack = (rd_req === 1'b1) ? (wcnt > dly && acks_left > 0) : (junk && $urandom_range(0, 1) == 1);
    rd_data = (rd_req === 1'b1) ? board[rd_addr] : 4'($urandom);
    if (rd_req === 1'b1 && rd_ack) begin
      acks_left--;
      if (fetching && nack < 4) begin
        lbm[nack] = board[frow * 4 + nack];
        nack++;
      end
    end
  endtask

  task automatic run_line(input int v, input int clr_at);
    for (int h = 0; h < 800; h++) cyc(v, h, clr_at);
  endtask

  task automatic run_lines(input int a, input int b);
    for (int v = a; v <= b; v++) run_line(v, -1);
  endtask

  // fast-forward: only the end-of-line count is presented, so line counters step once per vc
  task automatic skip(input int a, input int b);
    for (int v = a; v < b; v++) cyc(v, 799, -1);
  endtask

  initial begin
    pal = '{12'hCBA, 12'hEED, 12'hEEC, 12'hFB7, 12'hF96, 12'hF75, 12'hF53, 12'hEC7,
            12'hEC6, 12'hEC5, 12'hEC3, 12'hEC2, 12'h333, 12'h333, 12'h333, 12'h333};
    new_board();
    board[0] = 4'd1; board[1] = 4'd2; board[2] = 4'd3; board[3] = 4'd4;
    for (int i = 0; i < 4; i++) lbm[i] = 4'd0;
    fetching = 1'b0; err_exp = 1'b0; junk = 1'b0;
    frow = 0; nack = 0; wcnt = 0; dly = 0; dmin = 0; dmax = 0; acks_left = 1000;
    repeat (3) @(negedge dclk);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    clr = 1'b0;
    // zero-latency RAM, raster sweep across top, row change and bottom of the board
    skip(0, 69);
    run_lines(69, 75);
    skip(76, 170);
    run_lines(170, 172);
    skip(173, 469);
    run_lines(469, 471);
    skip(472, 510);
    run_lines(510, 511);
    // delayed acks: fixed 5 then random, with stray acks while idle
    new_board();
    dmin = 5; dmax = 5; junk = 1'b1;
    skip(0, 70);
    run_lines(70, 71);
    dmin = 0; dmax = 20;
    skip(72, 74);
    run_lines(74, 75);
    junk = 1'b0;
    // RAM never answers, then answers only twice
    new_board();
    acks_left = 0; dmin = 0; dmax = 3;
    skip(0, 74);
    run_lines(74, 75);
    acks_left = 2;
    run_lines(76, 77);
    // good frame afterwards: error flag must stay set
    acks_left = 1000;
    skip(0, 74);
    run_lines(74, 75);
    // reset pulse in the middle of a read, then a clean frame
    new_board();
    dmin = 10; dmax = 10;
    skip(0, 70);
    run_line(70, 788);
    skip(0, 70);
    run_lines(70, 71);
    dmin = 0; dmax = 8;
    skip(72, 74);
    run_lines(74, 75);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
